aes_enc_round_ctrl: RTL and testbench
=====================================

// Module: aes_enc_round_ctrl
// PURPOSE
//  Iterative AES encryption sequencer: accepts one 128-bit plaintext block and runs the
//  AddRoundKey/SubBytes/ShiftRows/MixColumns datapath one round per clock for Nr rounds.
//  Drives the round-key index to the external key-expansion store and returns the ciphertext.
//  Sits between the block-level valid/ready streams and the team's combinational round stages.
// PARAMETERS
//  DATA_W     128  block width; only 128 is supported.
//  RK_IDX_W   4    width of the round-key index; must be >= 4 so it can address keys 0..14.
// PORTS
//  clk          in   1    single clock; all state updates on rising edge.
//  rst_n        in   1    synchronous, active-low reset.
//  in_valid     in   1    plaintext block and key size are presented.
//  in_ready     out  1    controller can accept a block.
//  in_data      in   128  plaintext; byte 0 at [127:120], column-major, state[r][c] = byte r+4c.
//  in_key_size  in   2    00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=AES-128.
//  rk_idx       out  4    round-key index requested from the key store; combinational from FSM.
//  rk           in   128  round key for rk_idx; key store returns it in the same cycle (combinational).
//  out_valid    out  1    ciphertext is available.
//  out_ready    in   1    downstream accepts the ciphertext.
//  out_data     out  128  ciphertext, same byte order as in_data; driven from the state register.
//  busy         out  1    high in every state except IDLE.
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): FSM=IDLE, state reg=0, round cnt=0, nr reg=10, out_valid=0.
//    Reset wins over every other event, including mid-round. The partial block is discarded.
//  - Combinational outputs: in_ready=1 only in IDLE; busy=!IDLE; out_data=state reg in every state.
//  - FSM states: IDLE -> ROUND -> FINAL -> DONE -> IDLE.
//  - IDLE: rk_idx=0. When in_valid&&in_ready:
//      state <= in_data ^ rk (round 0 AddRoundKey); latch nr from in_key_size; cnt <= 1; go to ROUND.
//  - ROUND: rk_idx=cnt.
//      state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk; cnt <= cnt+1.
//      If cnt == nr-1, go to FINAL.
//  - FINAL: rk_idx=nr.
//      state <= ShiftRows(SubBytes(state)) ^ rk (no MixColumns); go to DONE; out_valid <= 1.
//  - DONE: rk_idx=0. out_valid held at 1; out_data stays stable until out_valid&&out_ready.
//      On the output handshake: out_valid <= 0, go to IDLE. in_ready is 1 in the next cycle;
//      a block cannot be accepted in the same cycle as the output handshake.
//  - Latency: from the input-handshake edge to out_valid high is nr cycles (10/12/14).
//    Throughput is one block per nr+2 cycles when out_ready is held at 1.
//  - in_data and in_key_size are sampled only at the input handshake.
//    Changes while busy are ignored. nr cannot change mid-block.
//  - in_key_size=11 behaves exactly as 00 (Nr=10).
//  - cnt is 4 bits and never exceeds 13. No wrap is possible.
//    rk_idx never exceeds 14.
//  - No X propagation: out_data is 0 after reset until the first block completes.
// CONFIGURATION
//  AES_CTRL_ABORT_EN defined:
//   - Adds input port abort (1 bit).
//   - abort=1 in ROUND, FINAL or DONE: next state IDLE, out_valid <= 0, state reg <= 0.
//     in_ready=1 in the following cycle.
//   - abort in IDLE is a no-op and blocks acceptance in that cycle (in_ready forced to 0).
//   - Priority: rst_n > abort > handshakes.
//  AES_CTRL_ABORT_EN undefined:
//   - The abort port does not exist. Every accepted block runs to DONE.
// TESTING
//  1. AES-128: pt 00112233445566778899aabbccddeeff, key 000102..0f, size 00
//     -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
//  2. AES-192: same pt, key 000102..17, size 01
//     -> ct dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles; rk_idx steps 0,1..12.
//  3. AES-256: same pt, key 000102..1f, size 10
//     -> ct 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
//  4. Backpressure: out_ready=0 for 5 cycles after out_valid
//     -> out_data stable, in_ready=0, busy=1; release -> IDLE next cycle, in_ready=1.
//  5. Reset at round 5 of an AES-256 block -> next cycle IDLE, out_valid=0, out_data=0.
//     A new AES-128 block then gives the correct ct.
//  6. size 11 with the AES-128 vector -> ct 69c4e0d8...; with ABORT_EN, abort in FINAL
//     -> IDLE, no out_valid pulse.

Source files
------------

// File: rtl/aes_enc_round_ctrl_if.sv
// Block-level streams and key-store lookup of the iterative AES encryption sequencer.
interface aes_enc_round_ctrl_if #(
    parameter int DATA_W   = 128,
    parameter int RK_IDX_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [1:0]          in_key_size;
    logic [RK_IDX_W-1:0] rk_idx;
    logic [DATA_W-1:0]   rk;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                busy;

    modport slave (
        input  in_valid, in_data, in_key_size, rk, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_key_size, rk, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128/192/256 encryption sequencer, one round per clock.
// Defining AES_CTRL_ABORT_EN adds an abort input that returns a busy controller to IDLE.
module aes_enc_round_ctrl #(
    parameter int DATA_W   = 128,
    parameter int RK_IDX_W = 4
) (
    input logic clk,
    input logic rst_n,
`ifdef AES_CTRL_ABORT_EN
    input logic abort,
`endif
    aes_enc_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

    fsm_e                fsm_q;
    logic [DATA_W-1:0]   state_q;
    logic [RK_IDX_W-1:0] cnt_q, nr_q, nr_d, rk_idx_w;
    logic                out_valid_q;
    logic                abort_w, in_ready_w;
    logic [DATA_W-1:0]   sr_w, mc_w;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // GF(2^8) inverse as x^254 = x^2 * x^4 * ... * x^128, followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = gmul(x, x);
        inv = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Byte r+4c sits at the top of column c; ShiftRows pulls row r from column c+r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr_w[DATA_W-1-8*(r+4*c) -: 8] =
                sbox(state_q[DATA_W-1-8*(r+4*((c+r)%4)) -: 8]);
        end
        assign mc_w[DATA_W-1-32*c -: 32] = mix_col(sr_w[DATA_W-1-32*c -: 32]);
    end

`ifdef AES_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        case (bus.in_key_size)
            2'b01:   nr_d = RK_IDX_W'(12);
            2'b10:   nr_d = RK_IDX_W'(14);
            default: nr_d = RK_IDX_W'(10);
        endcase
    end

    always_comb begin
        case (fsm_q)
            ROUND:   rk_idx_w = cnt_q;
            FINAL:   rk_idx_w = nr_q;
            default: rk_idx_w = '0;
        endcase
    end

    assign in_ready_w    = (fsm_q == IDLE) && !abort_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.busy      = (fsm_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = state_q;
    assign bus.rk_idx    = rk_idx_w;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            cnt_q       <= '0;
            nr_q        <= RK_IDX_W'(10);
            out_valid_q <= 1'b0;
        end else if (abort_w && fsm_q != IDLE) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_w) begin
                        state_q <= bus.in_data ^ bus.rk;
                        nr_q    <= nr_d;
                        cnt_q   <= RK_IDX_W'(1);
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= mc_w ^ bus.rk;
                    // Hold cnt on the last middle round so it never passes 13.
                    if (cnt_q == nr_q - RK_IDX_W'(1)) fsm_q <= FINAL;
                    else                              cnt_q <= cnt_q + RK_IDX_W'(1);
                end
                FINAL: begin
                    state_q     <= sr_w ^ bus.rk;
                    out_valid_q <= 1'b1;
                    fsm_q       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Randomized bench for aes_enc_round_ctrl against a byte-level AES reference model.
module tb_aes_enc_round_ctrl;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n;
    logic abort_s;
    int   n_err, n_chk;
    bit   chk_en;

    always #5 clk = ~clk;

    aes_enc_round_ctrl_if bus ();

    aes_enc_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef AES_CTRL_ABORT_EN
        .abort (abort_s),
`endif
        .bus   (bus)
    );

    // Reference: S-box table, key store and per-round state trace of the block being offered.
    logic [7:0]   sbox [256];
    logic [127:0] stim_ks [16];
    logic [127:0] stim_tr [15];
    int           stim_nr;

    assign bus.rk = stim_ks[bus.rk_idx];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input int k);
        return (k == 1) ? a : (k == 2) ? xt(a) : (xt(a) ^ a);
    endfunction

    function automatic int mcoef(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic gen_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    task automatic prep(input logic [255:0] key, input logic [127:0] pt, input logic [1:0] sz);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  u [16];
        logic [7:0]  a [4];
        logic [127:0] v;
        int nk, nr;
        nr = (sz == 2'b01) ? 12 : (sz == 2'b10) ? 14 : 10;
        nk = nr - 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            stim_ks[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ stim_ks[0][127-8*i -: 8];
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
        stim_tr[0] = v;
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) u[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = u[4*c+k];
                    for (int row = 0; row < 4; row++) begin
                        u[4*c+row] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            u[4*c+row] = u[4*c+row] ^ gm(a[k], mcoef((k - row + 4) % 4));
                    end
                end
            end
            for (int i = 0; i < 16; i++) s[i] = u[i] ^ stim_ks[r][127-8*i -: 8];
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
            stim_tr[r] = v;
        end
        stim_nr = nr;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Cycle model: m_p = 0 idle, 1..nr one period per round key, nr+1 waiting on output.
    int           m_p, m_nr;
    logic [127:0] m_out;
    logic [127:0] m_tr [15];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_p = 0; m_nr = 10; m_out = '0;
        end else if (abort_s && m_p != 0) begin
            m_p = 0; m_out = '0;
        end else if (m_p == 0) begin
            if (bus.in_valid && !abort_s) begin
                m_tr = stim_tr; m_nr = stim_nr; m_out = stim_tr[0]; m_p = 1;
            end
        end else if (m_p <= m_nr) begin
            m_out = m_tr[m_p];
            m_p++;
        end else if (bus.out_ready) begin
            m_p = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  128'(bus.in_ready),  128'((m_p == 0) && !abort_s));
            chk("busy",      128'(bus.busy),      128'(m_p != 0));
            chk("out_valid", 128'(bus.out_valid), 128'(m_p == m_nr + 1));
            chk("rk_idx",    128'(bus.rk_idx),    128'((m_p >= 1 && m_p <= m_nr) ? m_p : 0));
            chk("out_data",  bus.out_data,        m_out);
        end
    end

    task automatic accept_only(input logic [255:0] key, input logic [127:0] pt, input logic [1:0] sz);
        int n;
        prep(key, pt, sz);
        bus.in_data = pt; bus.in_key_size = sz; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 64) chk("accept_timeout", 128'(n), 128'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.in_key_size = 2'($urandom());
    endtask

    task automatic send(input logic [255:0] key, input logic [127:0] pt, input logic [1:0] sz,
                        input logic [127:0] exp_ct, input bit use_ct, input int stall, input bit rnd);
        int lat, n;
        bus.out_ready = (stall > 0) ? 1'b0 : 1'b1;
        accept_only(key, pt, sz);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; lat++;
        end
        chk("latency", 128'(lat), 128'(stim_nr));
        if (use_ct) chk("ciphertext", bus.out_data, exp_ct);
        if (stall > 0) begin
            repeat (stall) begin
                @(negedge clk);
                chk("stall_data", bus.out_data, exp_ct);
                chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
                chk("stall_busy", 128'(bus.busy), 128'(1));
            end
            #1 bus.out_ready = 1'b1;
            @(negedge clk);
            chk("release_in_ready", 128'(bus.in_ready), 128'(1));
            chk("release_busy", 128'(bus.busy), 128'(0));
            #1;
        end
        n = 0;
        while (bus.out_valid && n < 40) begin
            bus.out_ready = (rnd && n < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1; n++;
        end
        if (n >= 40) chk("drain_timeout", 128'(n), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit with errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        n_err = 0; n_chk = 0; chk_en = 0; abort_s = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_key_size = 2'b00; bus.out_ready = 1'b1;
        gen_sbox();
        chk("sbox_00", 128'(sbox[8'h00]), 128'h63);
        chk("sbox_01", 128'(sbox[8'h01]), 128'h7c);
        chk("sbox_53", 128'(sbox[8'h53]), 128'hed);
        prep(K192, PT, 2'b01); chk("model_ct192", stim_tr[12], CT192);
        prep(K256, PT, 2'b10); chk("model_ct256", stim_tr[14], CT256);
        prep(K128, PT, 2'b00); chk("model_ct128", stim_tr[10], CT128);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_data",  bus.out_data, 128'h0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_in_ready",  128'(bus.in_ready), 128'(1));
        chk("rst_busy",      128'(bus.busy), 128'(0));
        chk("rst_rk_idx",    128'(bus.rk_idx), 128'(0));
        #1 rst_n = 1'b1; chk_en = 1;

        send(K128, PT, 2'b00, CT128, 1, 0, 0);
        send(K192, PT, 2'b01, CT192, 1, 0, 0);
        send(K256, PT, 2'b10, CT256, 1, 0, 0);
        send(K128, PT, 2'b00, CT128, 1, 5, 0);
        send(K128, PT, 2'b11, CT128, 1, 0, 0);

        accept_only(K256, PT, 2'b10);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("midrst_out_data",  bus.out_data, 128'h0);
        chk("midrst_in_ready",  128'(bus.in_ready), 128'(1));
        #1;
        send(K128, PT, 2'b00, CT128, 1, 0, 0);

`ifdef AES_CTRL_ABORT_EN
        accept_only(K128, PT, 2'b00);
        repeat (9) @(posedge clk);
        #1 abort_s = 1'b1;
        @(posedge clk); #1 abort_s = 1'b0;
        @(negedge clk);
        chk("abort_in_ready",  128'(bus.in_ready), 128'(1));
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_pulse", 128'(bus.out_valid), 128'(0));
        end
        #1 abort_s = 1'b1; bus.in_valid = 1'b1;
        #1 chk("abort_idle_block", 128'(bus.in_ready), 128'(0));
        @(posedge clk); #1 abort_s = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", 128'(bus.busy), 128'(0));
        #1;
`endif

        for (int b = 0; b < 30; b++) begin
            logic [255:0] k;
            logic [127:0] p;
            k = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(k, p, 2'($urandom_range(0, 3)), 128'h0, 0, 0, 1);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
